// File: rtl/ra_stack_pkg.sv
// Shared constants for the return-address stack and the pc it feeds.
// Keeping the address width here means pc and ra_stack cannot disagree on it.
package ra_stack_pkg;

  localparam int ADDR_WIDTH = 8;
  localparam int RAS_DEPTH  = 4;
  localparam logic [ADDR_WIDTH-1:0] RESET_VECTOR = 8'h00;

  // Decoder request seen by the stack in one cycle; bit 1 is call, bit 0 is ret.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_RET  = 2'b01,
    OP_CALL = 2'b10,
    OP_TAIL = 2'b11
  } ras_op_e;

  // Folds the two decoder strobes into a single operation code.
  function automatic ras_op_e decodeOp(input logic call, input logic ret);
    return ras_op_e'({call, ret});
  endfunction

endpackage

// File: rtl/ra_stack_mem.sv
// DEPTH x WIDTH register file holding return addresses.
// Writes land on the clock edge; reads are combinational so the top entry
// is available to the pc load mux in the same cycle. Contents are never reset.
module ra_stack_mem
  import ra_stack_pkg::*;
#(
  parameter int WIDTH = ADDR_WIDTH,
  parameter int DEPTH = RAS_DEPTH
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Store one entry on each enabled clock edge.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ra_stack.sv
// Return-address stack between the decoder and pc.
// CALL pushes pc_in+1 and redirects to target, RET pops into the pc, and
// CALL+RET together replaces the top entry (tail call). The ld/addr pair is
// purely combinational so the pc loads on the same edge the stack updates.
module ra_stack
  import ra_stack_pkg::*;
#(
  parameter int WIDTH = ADDR_WIDTH,
  parameter int DEPTH = RAS_DEPTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_call,
  input  logic             i_ret,
  input  logic [WIDTH-1:0] i_pc_in,
  input  logic [WIDTH-1:0] i_target,
  output logic             o_ld,
  output logic [WIDTH-1:0] o_addr,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_ovf,
  output logic             o_unf
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = AW + 1;

  logic [SW-1:0]    r_sp;
  logic             r_ovf;
  logic             r_unf;

  logic             w_empty;
  logic             w_full;
  ras_op_e          w_op;
  logic [AW-1:0]    w_top;
  logic             w_we;
  logic [AW-1:0]    w_waddr;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_rdata;
  logic             w_ld;
  logic [WIDTH-1:0] w_addr;

  assign w_empty = (r_sp == '0);
  assign w_full  = (r_sp == SW'(DEPTH));
  assign w_op    = decodeOp(i_call, i_ret);
  assign w_top   = r_sp[AW-1:0] - AW'(1);
  assign w_wdata = i_pc_in + WIDTH'(1);

  ra_stack_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (w_top),
    .o_rdata (w_rdata)
  );

  // Pick the pc load request and the stack write for this cycle; reset suppresses both.
  always_comb begin
    w_ld    = 1'b0;
    w_addr  = '0;
    w_we    = 1'b0;
    w_waddr = r_sp[AW-1:0];
    if (!i_rst) begin
      case (w_op)
        OP_CALL: begin
          w_ld   = 1'b1;
          w_addr = i_target;
          w_we   = !w_full;
        end
        OP_RET: begin
          if (!w_empty) begin
            w_ld   = 1'b1;
            w_addr = w_rdata;
          end
        end
        OP_TAIL: begin
          w_ld   = 1'b1;
          w_addr = i_target;
          w_we   = 1'b1;
          if (!w_empty) begin
            w_waddr = w_top;
          end
        end
        default: begin
          w_ld = 1'b0;
        end
      endcase
    end
  end

  // Track occupancy and the sticky overflow/underflow flags.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sp  <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      case (w_op)
        OP_CALL: begin
          if (w_full) r_ovf <= 1'b1;
          else        r_sp  <= r_sp + SW'(1);
        end
        OP_RET: begin
          if (w_empty) r_unf <= 1'b1;
          else         r_sp  <= r_sp - SW'(1);
        end
        OP_TAIL: begin
          if (w_empty) r_sp <= r_sp + SW'(1);
        end
        default: begin
          r_sp <= r_sp;
        end
      endcase
    end
  end

  assign o_ld    = w_ld;
  assign o_addr  = w_addr;
  assign o_empty = w_empty;
  assign o_full  = w_full;
  assign o_ovf   = r_ovf;
  assign o_unf   = r_unf;

endmodule

// File: tb/tb_ra_stack.sv
// Testbench for ra_stack: directed scenarios followed by random traffic,
// all compared against a queue-based model of a bounded return-address stack.
module tb_ra_stack;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       call = 1'b0;
  logic       ret = 1'b0;
  logic [7:0] pcIn = 8'h00;
  logic [7:0] target = 8'h00;
  logic       ld;
  logic [7:0] addr;
  logic       empty;
  logic       full;
  logic       ovf;
  logic       unf;

  int checks = 0;
  int errors = 0;

  logic [7:0] modelStack [$];
  logic       modelOvf = 1'b0;
  logic       modelUnf = 1'b0;

  ra_stack dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_call   (call),
    .i_ret    (ret),
    .i_pc_in  (pcIn),
    .i_target (target),
    .o_ld     (ld),
    .o_addr   (addr),
    .o_empty  (empty),
    .o_full   (full),
    .o_ovf    (ovf),
    .o_unf    (unf)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // One comparison: counts it and reports any difference.
  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of decoder activity, checks the same-cycle redirect,
  // then advances the model and checks the registered flags after the edge.
  task automatic applyStimulus(input string tag, input logic rs, input logic c, input logic r,
                               input logic [7:0] pc, input logic [7:0] tg);
    logic       expLd;
    logic [7:0] expAddr;
    @(negedge clk);
    rst = rs; call = c; ret = r; pcIn = pc; target = tg;
    #1;
    expLd = 1'b0;
    expAddr = 8'h00;
    if (!rs) begin
      if (c) begin
        expLd = 1'b1;
        expAddr = tg;
      end else if (r && modelStack.size() > 0) begin
        expLd = 1'b1;
        expAddr = modelStack[modelStack.size()-1];
      end
    end
    checkOutput({tag, ".ld"}, {7'b0, ld}, {7'b0, expLd});
    checkOutput({tag, ".addr"}, addr, expAddr);
    @(posedge clk);
    if (rs) begin
      modelStack.delete();
      modelOvf = 1'b0;
      modelUnf = 1'b0;
    end else if (c && r) begin
      if (modelStack.size() > 0) modelStack[modelStack.size()-1] = pc + 8'd1;
      else                       modelStack.push_back(pc + 8'd1);
    end else if (c) begin
      if (modelStack.size() < DEPTH) modelStack.push_back(pc + 8'd1);
      else                           modelOvf = 1'b1;
    end else if (r) begin
      if (modelStack.size() > 0) void'(modelStack.pop_back());
      else                       modelUnf = 1'b1;
    end
    #1;
    checkOutput({tag, ".empty"}, {7'b0, empty}, {7'b0, (modelStack.size() == 0)});
    checkOutput({tag, ".full"}, {7'b0, full}, {7'b0, (modelStack.size() == DEPTH)});
    checkOutput({tag, ".ovf"}, {7'b0, ovf}, {7'b0, modelOvf});
    checkOutput({tag, ".unf"}, {7'b0, unf}, {7'b0, modelUnf});
  endtask

  // Directed scenarios, then random traffic, then the summary.
  initial begin
    applyStimulus("reset", 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    applyStimulus("idle", 1'b0, 1'b0, 1'b0, 8'h33, 8'h44);

    applyStimulus("call1", 1'b0, 1'b1, 1'b0, 8'h10, 8'h40);
    applyStimulus("idle2", 1'b0, 1'b0, 1'b0, 8'h40, 8'h00);
    applyStimulus("ret1", 1'b0, 1'b0, 1'b1, 8'h41, 8'h00);

    applyStimulus("fill1", 1'b0, 1'b1, 1'b0, 8'h01, 8'h50);
    applyStimulus("fill2", 1'b0, 1'b1, 1'b0, 8'h02, 8'h60);
    applyStimulus("fill3", 1'b0, 1'b1, 1'b0, 8'h03, 8'h70);
    applyStimulus("fill4", 1'b0, 1'b1, 1'b0, 8'h04, 8'h80);
    applyStimulus("ovfCall", 1'b0, 1'b1, 1'b0, 8'h05, 8'h90);
    applyStimulus("pop1", 1'b0, 1'b0, 1'b1, 8'h90, 8'h00);
    applyStimulus("pop2", 1'b0, 1'b0, 1'b1, 8'h05, 8'h00);
    applyStimulus("pop3", 1'b0, 1'b0, 1'b1, 8'h04, 8'h00);
    applyStimulus("pop4", 1'b0, 1'b0, 1'b1, 8'h03, 8'h00);

    applyStimulus("unfRet", 1'b0, 1'b0, 1'b1, 8'h02, 8'h00);
    applyStimulus("unfHold", 1'b0, 1'b1, 1'b0, 8'h07, 8'h08);
    applyStimulus("unfClear", 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);

    applyStimulus("wrapCall", 1'b0, 1'b1, 1'b0, 8'hFF, 8'h30);
    applyStimulus("tailCall", 1'b0, 1'b1, 1'b1, 8'h20, 8'h80);
    applyStimulus("tailRet", 1'b0, 1'b0, 1'b1, 8'h81, 8'h00);
    applyStimulus("wrapRet", 1'b0, 1'b0, 1'b1, 8'h22, 8'h00);
    applyStimulus("tailEmpty", 1'b0, 1'b1, 1'b1, 8'h55, 8'hA0);
    applyStimulus("tailEmptyRet", 1'b0, 1'b0, 1'b1, 8'hA0, 8'h00);

    applyStimulus("midA", 1'b0, 1'b1, 1'b0, 8'h11, 8'h12);
    applyStimulus("midB", 1'b0, 1'b1, 1'b0, 8'h13, 8'h14);
    applyStimulus("midRst", 1'b1, 1'b1, 1'b0, 8'h15, 8'h16);
    applyStimulus("midAfter", 1'b0, 1'b0, 1'b1, 8'h17, 8'h00);
    applyStimulus("midClear", 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);

    for (int i = 0; i < 400; i++) begin
      logic       rs;
      logic       c;
      logic       r;
      logic [7:0] pc;
      rs = ($urandom_range(0, 29) == 0);
      c  = ($urandom_range(0, 2) == 0);
      r  = ($urandom_range(0, 2) == 0);
      pc = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom);
      applyStimulus("rand", rs, c, r, pc, 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
